imem_rsp: RTL and testbench
===========================

IMEM_RSP -- requirements
Module: imem_rsp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and PC width.
REQ-002 SHALL have parameter IMEM_SZ_IN_KB, default 1, memory size; depth = IMEM_SZ_IN_KB*256 words.
REQ-003 SHALL have parameter LATENCY, default 2, legal 1..7, cycles from request accept to response valid.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); arst input 1 (async reset, active high).
REQ-005 req_valid_in input 1: fetch request valid.
REQ-006 req_ready_out output 1: request accepted when req_valid_in & req_ready_out at a rising edge.
REQ-007 req_pc_in input DATA_WIDTH: byte address of the instruction.
REQ-008 flush_in input 1: branch redirect; discards any outstanding request or response.
REQ-009 rsp_valid_out output 1: response valid.
REQ-010 rsp_ready_in input 1: consumer accepts the response; low equals fetch stall.
REQ-011 rsp_instr_out output DATA_WIDTH: fetched instruction.
REQ-012 rsp_pc_out output DATA_WIDTH: PC of the returned instruction.
REQ-013 rsp_err_out output 1: misaligned or out-of-range fetch.
REQ-014 ld_en_in input 1, ld_addr_in input log2(depth), ld_data_in input DATA_WIDTH: word-indexed memory load port.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; single outstanding request.
REQ-016 req_ready_out SHALL be (IDLE | (RESP & rsp_ready_in)) & ~flush_in.
REQ-017 On accept, the FSM SHALL capture req_pc_in, read mem[req_pc_in[.. :2]] (read-first), load the latency counter with LATENCY-1, and go to WAIT, or straight to RESP if LATENCY=1.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, so rsp_valid_out rises exactly LATENCY edges after the accept edge.
REQ-019 In RESP, rsp_valid_out=1 and rsp_instr_out/rsp_pc_out/rsp_err_out SHALL stay stable while rsp_ready_in=0.
REQ-020 RESP with rsp_ready_in=1 SHALL complete the transfer: go to IDLE, or reload WAIT/RESP if a new request is accepted on the same edge (back-to-back, no bubble for LATENCY=1).
REQ-021 flush_in SHALL take priority over everything: from WAIT or RESP, go to IDLE on the next edge, with no response for the discarded request and no request accepted that cycle.
REQ-022 A request is an error if req_pc_in[1:0]!=0 or word index >= depth; it SHALL still obey latency and return rsp_err_out=1 with rsp_instr_out=NOP (0x00000013).
REQ-023 A load write to the same word on the accept edge SHALL not affect that fetch (old data); ld_en_in SHALL work in any state.
REQ-024 Outputs SHALL be registered; rsp_* SHALL be driven 0 when rsp_valid_out=0.

Reset
REQ-025 On arst: state=IDLE, counter=0, rsp_valid_out=0, rsp_instr_out=0, rsp_pc_out=0, rsp_err_out=0; req_ready_out=1 after release.
REQ-026 arst mid-transaction SHALL drop the outstanding request without emitting a response; memory contents are not reset.

Structure
REQ-027 imem_rsp_pkg SHALL hold the state enum, the NOP constant, and imem_req_t/imem_rsp_t structs (pc, instr, err).
REQ-028 Storage SHALL be a sub-module imem_array (1 read port, 1 write port, read-first); the rest is FSM plus counter.

Verification
REQ-029 LATENCY=2, mem[3]=0xDEADBEEF, request pc=0x0C at edge 0 -> rsp_valid_out=1 after edge 2, instr=0xDEADBEEF, pc=0x0C, err=0.
REQ-030 Hold rsp_ready_in=0 for 5 cycles in RESP -> outputs stable, req_ready_out=0; ready=1 plus a new request pc=0x10 -> accepted on the same edge.
REQ-031 Flush in WAIT after accepting pc=0x20 -> no response, IDLE next cycle; the following request pc=0x24 returns mem[9].
REQ-032 pc=0x02 and pc=0x400 (depth 256) -> err=1, instr=0x00000013 after LATENCY cycles.
REQ-033 arst asserted in WAIT -> rsp_valid_out=0 immediately, IDLE on release; a load write to word 5 on the accept edge of pc=0x14 -> old word returned.
REQ-034 LATENCY=1, back-to-back requests pc=0,4,8 with rsp_ready_in=1 -> one response per cycle, in order.

Source files
------------

// File: rtl/imem_rsp_pkg.sv
// Shared types and constants for the instruction-memory response block.
package imem_rsp_pkg;

    localparam int unsigned IMEM_XLEN = 32;
    localparam int unsigned CNT_W     = 3;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic [IMEM_XLEN-1:0] pc;
    } imem_req_t;

    typedef struct packed {
        logic [IMEM_XLEN-1:0] pc;
        logic [IMEM_XLEN-1:0] instr;
        logic                 err;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_if.sv
// Fetch request/response handshake plus word-indexed load port.
interface imem_rsp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [DATA_WIDTH-1:0] req_pc_in;
    logic                  flush_in;
    logic                  rsp_valid_out;
    logic                  rsp_ready_in;
    logic [DATA_WIDTH-1:0] rsp_instr_out;
    logic [DATA_WIDTH-1:0] rsp_pc_out;
    logic                  rsp_err_out;
    logic                  ld_en_in;
    logic [ADDR_WIDTH-1:0] ld_addr_in;
    logic [DATA_WIDTH-1:0] ld_data_in;

    modport master (
        output req_valid_in, req_pc_in, flush_in, rsp_ready_in,
               ld_en_in, ld_addr_in, ld_data_in,
        input  req_ready_out, rsp_valid_out, rsp_instr_out, rsp_pc_out, rsp_err_out
    );

    modport slave (
        input  req_valid_in, req_pc_in, flush_in, rsp_ready_in,
               ld_en_in, ld_addr_in, ld_data_in,
        output req_ready_out, rsp_valid_out, rsp_instr_out, rsp_pc_out, rsp_err_out
    );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one write port, one asynchronous read port.
// Reads sampled on a write edge see the old word (read-first).
module imem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_in,
    input  logic [ADDR_W-1:0]     wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    input  logic [ADDR_W-1:0]     rd_addr_in,
    output logic [DATA_WIDTH-1:0] rd_data_out
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/imem_rsp.sv
// Single-outstanding instruction fetch with fixed response latency,
// backpressure, flush and error reporting for misaligned/out-of-range PCs.
module imem_rsp
    import imem_rsp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned IMEM_SZ_IN_KB = 1,
    parameter int unsigned LATENCY       = 2
) (
    input  logic        clk,
    input  logic        arst,
    imem_rsp_if.slave   bus
);
    localparam int unsigned DEPTH  = IMEM_SZ_IN_KB * 256;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("imem_rsp: LATENCY must be within 1..7");
    end

    imem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic                  hold_err_q, hold_err_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-3:0] word_idx;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] req_instr;
    logic                  ready_c;
    logic                  accept;

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk         (clk),
        .wr_en_in    (bus.ld_en_in),
        .wr_addr_in  (bus.ld_addr_in),
        .wr_data_in  (bus.ld_data_in),
        .rd_addr_in  (rd_addr),
        .rd_data_out (rd_data)
    );

    // Request decode: memory word, error classification and handshake.
    always_comb begin
        word_idx  = bus.req_pc_in[DATA_WIDTH-1:2];
        rd_addr   = bus.req_pc_in[ADDR_W+1:2];
        req_err   = (bus.req_pc_in[1:0] != 2'b00) ||
                    (word_idx >= (DATA_WIDTH-2)'(DEPTH));
        req_instr = req_err ? DATA_WIDTH'(NOP_INSTR) : rd_data;
        ready_c   = ((state_q == IDLE) ||
                     ((state_q == RESP) && bus.rsp_ready_in)) && !bus.flush_in;
        accept    = bus.req_valid_in && ready_c;
    end

    // Next-state and response register logic; accept implies no flush.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        hold_err_d   = hold_err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_instr_d  = rsp_instr_q;
        rsp_pc_d     = rsp_pc_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_instr_d = hold_instr_q;
                    rsp_pc_d    = hold_pc_q;
                    rsp_err_d   = hold_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_in) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_instr_d = '0;
                    rsp_pc_d    = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_in) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            rsp_instr_d = '0;
            rsp_pc_d    = '0;
            rsp_err_d   = 1'b0;
        end

        if (accept) begin
            hold_pc_d    = bus.req_pc_in;
            hold_instr_d = req_instr;
            hold_err_d   = req_err;
            if (LATENCY == 1) begin
                state_d     = RESP;
                cnt_d       = '0;
                rsp_valid_d = 1'b1;
                rsp_instr_d = req_instr;
                rsp_pc_d    = bus.req_pc_in;
                rsp_err_d   = req_err;
            end else begin
                state_d     = WAIT;
                cnt_d       = CNT_W'(LATENCY - 1);
                rsp_valid_d = 1'b0;
                rsp_instr_d = '0;
                rsp_pc_d    = '0;
                rsp_err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_err_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_instr_q  <= '0;
            rsp_pc_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_err_q   <= hold_err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_instr_q  <= rsp_instr_d;
            rsp_pc_q     <= rsp_pc_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready_out = ready_c;
    assign bus.rsp_valid_out = rsp_valid_q;
    assign bus.rsp_instr_out = rsp_instr_q;
    assign bus.rsp_pc_out    = rsp_pc_q;
    assign bus.rsp_err_out   = rsp_err_q;

endmodule

// File: tb/tb_imem_rsp.sv
// Directed bench for imem_rsp: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_imem_rsp;
    import imem_rsp_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic arst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    imem_rsp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    imem_rsp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    imem_rsp #(.DATA_WIDTH(DW), .IMEM_SZ_IN_KB(1), .LATENCY(2)) u_dut_a (
        .clk (clk), .arst (arst), .bus (bus_a)
    );
    imem_rsp #(.DATA_WIDTH(DW), .IMEM_SZ_IN_KB(1), .LATENCY(1)) u_dut_b (
        .clk (clk), .arst (arst), .bus (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic imem_rsp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic err);
        imem_rsp_t r;
        r.pc    = pc;
        r.instr = instr;
        r.err   = err;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input string tag, input logic v, input imem_rsp_t r);
        check({tag, ".valid"}, 64'(bus_a.rsp_valid_out), 64'(v));
        check({tag, ".instr"}, 64'(bus_a.rsp_instr_out), 64'(r.instr));
        check({tag, ".pc"},    64'(bus_a.rsp_pc_out),    64'(r.pc));
        check({tag, ".err"},   64'(bus_a.rsp_err_out),   64'(r.err));
    endtask

    task automatic exp_b(input string tag, input logic v, input imem_rsp_t r);
        check({tag, ".valid"}, 64'(bus_b.rsp_valid_out), 64'(v));
        check({tag, ".instr"}, 64'(bus_b.rsp_instr_out), 64'(r.instr));
        check({tag, ".pc"},    64'(bus_b.rsp_pc_out),    64'(r.pc));
        check({tag, ".err"},   64'(bus_b.rsp_err_out),   64'(r.err));
    endtask

    task automatic load_a(input logic [AW-1:0] addr, input logic [31:0] data);
        bus_a.ld_en_in   = 1'b1;
        bus_a.ld_addr_in = addr;
        bus_a.ld_data_in = data;
        step();
        bus_a.ld_en_in   = 1'b0;
    endtask

    task automatic load_b(input logic [AW-1:0] addr, input logic [31:0] data);
        bus_b.ld_en_in   = 1'b1;
        bus_b.ld_addr_in = addr;
        bus_b.ld_data_in = data;
        step();
        bus_b.ld_en_in   = 1'b0;
    endtask

    // Issue one request on instance A and return once it has been accepted.
    task automatic req_a(input logic [31:0] pc);
        bus_a.req_valid_in = 1'b1;
        bus_a.req_pc_in    = pc;
        step();
        bus_a.req_valid_in = 1'b0;
    endtask

    imem_rsp_t zero;

    initial begin
        zero = mk(32'h0, 32'h0, 1'b0);
        arst = 1'b1;
        bus_a.req_valid_in = 1'b0; bus_a.req_pc_in = '0; bus_a.flush_in = 1'b0;
        bus_a.rsp_ready_in = 1'b1; bus_a.ld_en_in = 1'b0; bus_a.ld_addr_in = '0;
        bus_a.ld_data_in = '0;
        bus_b.req_valid_in = 1'b0; bus_b.req_pc_in = '0; bus_b.flush_in = 1'b0;
        bus_b.rsp_ready_in = 1'b1; bus_b.ld_en_in = 1'b0; bus_b.ld_addr_in = '0;
        bus_b.ld_data_in = '0;

        repeat (3) step();
        exp_a("reset", 1'b0, zero);
        exp_b("reset_b", 1'b0, zero);
        arst = 1'b0;
        #1;
        check("reset.ready", 64'(bus_a.req_ready_out), 64'd1);

        load_a(8'd3, 32'hDEAD_BEEF);
        load_a(8'd4, 32'h1111_1111);
        load_a(8'd9, 32'h9999_9999);
        load_a(8'd5, 32'h5555_5555);
        load_b(8'd0, 32'hB000_0000);
        load_b(8'd1, 32'hB000_0001);
        load_b(8'd2, 32'hB000_0002);

        // Basic latency-2 fetch held under backpressure
        bus_a.rsp_ready_in = 1'b0;
        req_a(32'h0C);
        exp_a("lat.e0", 1'b0, zero);
        step();
        exp_a("lat.e1", 1'b0, zero);
        step();
        exp_a("lat.e2", 1'b1, mk(32'h0C, 32'hDEAD_BEEF, 1'b0));

        for (int i = 0; i < 5; i++) begin
            step();
            exp_a("hold", 1'b1, mk(32'h0C, 32'hDEAD_BEEF, 1'b0));
            check("hold.ready", 64'(bus_a.req_ready_out), 64'd0);
        end

        // Release together with a new request: accepted on the completing edge
        bus_a.rsp_ready_in = 1'b1;
        bus_a.req_valid_in = 1'b1;
        bus_a.req_pc_in    = 32'h10;
        #1;
        check("b2b.ready", 64'(bus_a.req_ready_out), 64'd1);
        step();
        bus_a.req_valid_in = 1'b0;
        exp_a("b2b.e0", 1'b0, zero);
        step();
        exp_a("b2b.e1", 1'b0, zero);
        step();
        exp_a("b2b.e2", 1'b1, mk(32'h10, 32'h1111_1111, 1'b0));
        step();
        exp_a("b2b.done", 1'b0, zero);

        // Flush in WAIT discards the fetch
        req_a(32'h20);
        bus_a.flush_in = 1'b1;
        #1;
        check("flush.ready", 64'(bus_a.req_ready_out), 64'd0);
        step();
        bus_a.flush_in = 1'b0;
        exp_a("flush.e1", 1'b0, zero);
        #1;
        check("flush.idle_ready", 64'(bus_a.req_ready_out), 64'd1);
        step();
        exp_a("flush.e2", 1'b0, zero);
        step();
        exp_a("flush.e3", 1'b0, zero);
        req_a(32'h24);
        step();
        step();
        exp_a("after_flush", 1'b1, mk(32'h24, 32'h9999_9999, 1'b0));
        step();

        // Error fetches: misaligned and out of range
        req_a(32'h02);
        step();
        exp_a("misal.e1", 1'b0, zero);
        step();
        exp_a("misal", 1'b1, mk(32'h02, 32'h0000_0013, 1'b1));
        step();
        req_a(32'h400);
        step();
        exp_a("oor.e1", 1'b0, zero);
        step();
        exp_a("oor", 1'b1, mk(32'h400, 32'h0000_0013, 1'b1));
        step();

        // LATENCY=1 back-to-back stream
        bus_b.req_valid_in = 1'b1;
        bus_b.req_pc_in    = 32'h0;
        step();
        exp_b("l1.r0", 1'b1, mk(32'h0, 32'hB000_0000, 1'b0));
        bus_b.req_pc_in = 32'h4;
        #1;
        check("l1.ready", 64'(bus_b.req_ready_out), 64'd1);
        step();
        exp_b("l1.r1", 1'b1, mk(32'h4, 32'hB000_0001, 1'b0));
        bus_b.req_pc_in = 32'h8;
        step();
        exp_b("l1.r2", 1'b1, mk(32'h8, 32'hB000_0002, 1'b0));
        bus_b.req_valid_in = 1'b0;
        step();
        exp_b("l1.done", 1'b0, zero);

        // Async reset while WAIT drops the request
        req_a(32'h0C);
        arst = 1'b1;
        #1;
        exp_a("rst.wait", 1'b0, zero);
        step();
        step();
        arst = 1'b0;
        #1;
        check("rst.ready", 64'(bus_a.req_ready_out), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_a("rst.no_rsp", 1'b0, zero);
        end

        // Async reset while RESP clears outputs at once
        bus_a.rsp_ready_in = 1'b0;
        req_a(32'h0C);
        step();
        step();
        exp_a("rst.pre", 1'b1, mk(32'h0C, 32'hDEAD_BEEF, 1'b0));
        arst = 1'b1;
        #1;
        exp_a("rst.resp", 1'b0, zero);
        step();
        arst = 1'b0;
        bus_a.rsp_ready_in = 1'b1;
        step();

        // Load to the fetched word on the accept edge returns the old word
        bus_a.ld_en_in     = 1'b1;
        bus_a.ld_addr_in   = 8'd5;
        bus_a.ld_data_in   = 32'hAAAA_AAAA;
        req_a(32'h14);
        bus_a.ld_en_in     = 1'b0;
        step();
        step();
        exp_a("rdfirst.old", 1'b1, mk(32'h14, 32'h5555_5555, 1'b0));
        step();
        req_a(32'h14);
        step();
        step();
        exp_a("rdfirst.new", 1'b1, mk(32'h14, 32'hAAAA_AAAA, 1'b0));
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
